// File: rtl/usb_hex_logger.sv
// usb_hex_logger: packet byte stream -> uppercase ASCII hex text for the debug UART.
// Define HEXLOG_SEQNUM_EN to prefix each packet with an 8-bit sequence number "NN:".
module usb_hex_logger #(
   parameter int unsigned MIN_GAP  = 2,
   parameter logic [7:0]  SEP_CHAR = 8'h20,
   parameter int unsigned MAX_LINE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       full,
   output logic       busy
);

   localparam int unsigned GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
   localparam int unsigned LW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_HI   = 4'd1;
   localparam logic [3:0] S_LO   = 4'd2;
   localparam logic [3:0] S_SEP  = 4'd3;
   localparam logic [3:0] S_CR   = 4'd4;
   localparam logic [3:0] S_LF   = 4'd5;
   localparam logic [3:0] S_SQH  = 4'd6;
   localparam logic [3:0] S_SQL  = 4'd7;
   localparam logic [3:0] S_COL  = 4'd8;

   logic [3:0]    state;
   logic [7:0]    byte_q;
   logic          last_q;
   logic [LW-1:0] line_cnt;
   logic [GW-1:0] gap_cnt;
   logic [7:0]    char_c;
   logic [3:0]    nxt_c;
   logic          brk;
   logic          emit;
`ifdef HEXLOG_SEQNUM_EN
   logic [7:0]    seq;
   logic          first_q;
`endif

   function automatic logic [7:0] hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);
   assign brk      = last_q || (line_cnt == LW'(MAX_LINE - 1));
   assign emit     = busy && (gap_cnt == '0) && !full;

   always_comb begin
      char_c = 8'h00;
      nxt_c  = S_IDLE;
      unique case (state)
         S_HI: begin
            char_c = hex(byte_q[7:4]);
            nxt_c  = S_LO;
         end
         S_LO: begin
            char_c = hex(byte_q[3:0]);
            nxt_c  = brk ? S_CR : S_SEP;
         end
         S_SEP: begin
            char_c = SEP_CHAR;
            nxt_c  = S_IDLE;
         end
         S_CR: begin
            char_c = 8'h0D;
            nxt_c  = S_LF;
         end
         S_LF: begin
            char_c = 8'h0A;
            nxt_c  = S_IDLE;
         end
`ifdef HEXLOG_SEQNUM_EN
         S_SQH: begin
            char_c = hex(seq[7:4]);
            nxt_c  = S_SQL;
         end
         S_SQL: begin
            char_c = hex(seq[3:0]);
            nxt_c  = S_COL;
         end
         S_COL: begin
            char_c = 8'h3A;
            nxt_c  = S_HI;
         end
`endif
         default: begin
            char_c = 8'h00;
            nxt_c  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         byte_q    <= 8'h00;
         last_q    <= 1'b0;
         line_cnt  <= '0;
         gap_cnt   <= '0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
`ifdef HEXLOG_SEQNUM_EN
         seq       <= 8'h00;
         first_q   <= 1'b1;
`endif
      end else begin
         out_valid <= 1'b0;
         if (gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
         if (state == S_IDLE) begin
            if (in_valid) begin
               byte_q <= in_data;
               last_q <= in_last;
`ifdef HEXLOG_SEQNUM_EN
               state   <= first_q ? S_SQH : S_HI;
               first_q <= 1'b0;
`else
               state  <= S_HI;
`endif
            end
         end else if (emit) begin
            out_valid <= 1'b1;
            out_data  <= char_c;
            state     <= nxt_c;
            gap_cnt   <= GW'(MIN_GAP);
            if (state == S_LO)
               line_cnt <= brk ? '0 : line_cnt + 1'b1;
`ifdef HEXLOG_SEQNUM_EN
            // Only the LF that closes a packet advances the sequence.
            if (state == S_LF && last_q) begin
               seq     <= seq + 8'h01;
               first_q <= 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_usb_hex_logger.sv
// tb_usb_hex_logger: directed and randomized checks of usb_hex_logger
// against a character-queue reference model.
module tb_usb_hex_logger;

   localparam int MIN_GAP  = 2;
   localparam int MAX_LINE = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       full = 1'b0;
   logic       busy;

   usb_hex_logger #(
      .MIN_GAP(MIN_GAP),
      .SEP_CHAR(8'h20),
      .MAX_LINE(MAX_LINE)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_last(in_last),
      .in_ready(in_ready),
      .out_data(out_data),
      .out_valid(out_valid),
      .full(full),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_cyc = 0;
   bit have_last = 0;
   logic [7:0] held = 8'h00;
   logic full_at_edge = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] cap_q[$];
   int         cap_t[$];

   int col = 0;
   logic [7:0] seq_m = 8'h00;
   bit first_m = 1;

   always @(posedge clk) begin
      cyc = cyc + 1;
      full_at_edge = full;
   end

   function automatic logic [7:0] hx(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
   endfunction

   task automatic model_byte(input logic [7:0] b, input bit last);
`ifdef HEXLOG_SEQNUM_EN
      if (first_m) begin
         exp_q.push_back(hx(seq_m[7:4]));
         exp_q.push_back(hx(seq_m[3:0]));
         exp_q.push_back(8'h3A);
         first_m = 0;
      end
`endif
      exp_q.push_back(hx(b[7:4]));
      exp_q.push_back(hx(b[3:0]));
      if (last || col == MAX_LINE - 1) begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
         col = 0;
         if (last) begin
            seq_m = seq_m + 8'h01;
            first_m = 1;
         end
      end else begin
         exp_q.push_back(8'h20);
         col = col + 1;
      end
   endtask

   // Every emitted character is matched against the model queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL char: got=%02h want=none", out_data);
            end else if (out_data !== exp_q[0]) begin
               failures++;
               $display("FAIL char: got=%02h want=%02h", out_data, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               void'(exp_q.pop_front());
            end
            checks++;
            if (full_at_edge) begin
               failures++;
               $display("FAIL full_write: got=1 want=0 at cycle %0d", cyc);
            end
            checks++;
            if (have_last && cyc - last_cyc < MIN_GAP + 1) begin
               failures++;
               $display("FAIL gap: got=%0d want>=%0d", cyc - last_cyc, MIN_GAP + 1);
            end
            last_cyc = cyc;
            have_last = 1;
            held = out_data;
            cap_q.push_back(out_data);
            cap_t.push_back(cyc);
         end else begin
            checks++;
            if (out_data !== held) begin
               failures++;
               $display("FAIL hold: got=%02h want=%02h", out_data, held);
            end
         end
         checks++;
         if (in_ready === busy) begin
            failures++;
            $display("FAIL ready_busy: in_ready=%b busy=%b", in_ready, busy);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit last, input int pre);
      int n;
      bit ok;
      n = 0;
      ok = 0;
      @(posedge clk);
      #2;
      repeat (pre) @(posedge clk);
      #2;
      in_data = b;
      in_last = last;
      in_valid = 1'b1;
      while (!ok && n < 2000) begin
         @(negedge clk);
         if (in_ready) ok = 1;
         else n++;
      end
      if (!ok) begin
         failures++;
         $display("FAIL accept_timeout: got=no_ready want=ready");
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         model_byte(b, last);
         #2;
         in_valid = 1'b0;
         in_data = 8'($urandom);
         in_last = 1'($urandom);
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_accept: got=%b want=0", in_ready);
         end
      end
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || busy) begin
         failures++;
         $display("FAIL %s drain: got=%0d pending want=0", nm, exp_q.size());
      end
   endtask

   task automatic check_cap(input string nm, input string s);
      int n;
      n = s.len() / 2;
      checks++;
      if (cap_q.size() != n) begin
         failures++;
         $display("FAIL %s count: got=%0d want=%0d", nm, cap_q.size(), n);
      end
      for (int i = 0; i < n && i < cap_q.size(); i++) begin
         string t;
         logic [7:0] w;
         t = s.substr(2 * i, 2 * i + 1);
         w = 8'(t.atohex());
         checks++;
         if (cap_q[i] !== w) begin
            failures++;
            $display("FAIL %s[%0d]: got=%02h want=%02h", nm, i, cap_q[i], w);
         end
      end
   endtask

   task automatic clear_cap();
      cap_q.delete();
      cap_t.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      col = 0;
      seq_m = 8'h00;
      first_m = 1;
      held = 8'h00;
      have_last = 0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 8'h00) begin
         failures++;
         $display("FAIL reset: got=v%b r%b b%b d%02h want=v0 r1 b0 d00",
                  out_valid, in_ready, busy, out_data);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      string s;
      bit done;
      repeat (3) @(posedge clk);
      do_reset();

`ifndef HEXLOG_SEQNUM_EN
      clear_cap();
      send_byte(8'hA5, 1, 0);
      wait_idle("t1");
      check_cap("t1", "41350D0A");
      for (int i = 1; i < cap_t.size(); i++) begin
         checks++;
         if (cap_t[i] - cap_t[i-1] != MIN_GAP + 1) begin
            failures++;
            $display("FAIL t1_spacing: got=%0d want=%0d", cap_t[i] - cap_t[i-1], MIN_GAP + 1);
         end
      end

      clear_cap();
      send_byte(8'h00, 0, 0);
      send_byte(8'hFF, 0, 1);
      send_byte(8'h7E, 1, 0);
      wait_idle("t2");
      check_cap("t2", "30302046462037450D0A");

      clear_cap();
      send_byte(8'h3C, 1, 0);
      for (int n = 0; n < 200 && cap_q.size() < 1; n++) @(negedge clk);
      full = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      full = 1'b0;
      wait_idle("t3");
      check_cap("t3", "33430D0A");

      clear_cap();
      for (int i = 0; i < 17; i++) send_byte(8'h11, (i == 16), 0);
      wait_idle("t4");
      s = "";
      for (int i = 0; i < 16; i++) s = {s, (i < 15) ? "313120" : "3131"};
      s = {s, "0D0A31310D0A"};
      check_cap("t4", s);

      clear_cap();
      send_byte(8'h5A, 1, 0);
      for (int n = 0; n < 200 && cap_q.size() < 1; n++) @(negedge clk);
      do_reset();
      clear_cap();
      send_byte(8'h01, 1, 0);
      wait_idle("t5");
      check_cap("t5", "30310D0A");
`else
      clear_cap();
      send_byte(8'h01, 1, 0);
      send_byte(8'h02, 1, 0);
      wait_idle("t6");
      check_cap("t6", "30303A30310D0A30313A30320D0A");
      for (int i = 2; i < 256; i++) send_byte(8'($urandom), 1, 0);
      wait_idle("t6b");
      clear_cap();
      send_byte(8'h33, 1, 0);
      wait_idle("t6c");
      check_cap("t6c", "30303A33330D0A");
      do_reset();
`endif

      done = 0;
      fork
         begin
            for (int p = 0; p < 30; p++) begin
               int len;
               len = $urandom_range(1, 40);
               for (int i = 0; i < len; i++)
                  send_byte(8'($urandom), (i == len - 1), $urandom_range(0, 3));
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #2;
               full = ($urandom_range(0, 3) == 0);
            end
            full = 1'b0;
         end
      join
      wait_idle("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
